// File: rtl/logic_pkg.sv
`default_nettype none
// logic_pkg: shared opcode/state encodings and word width for the shared logic unit.
package logic_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } logic_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/logic_unit_16.sv
`default_nettype none
// logic_unit_16: combinational bitwise OR/AND/XOR/NOT-A selector over one word.
module logic_unit_16
  import logic_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] or_out;
  logic [WIDTH-1:0] and_out;
  logic [WIDTH-1:0] xor_out;
  logic [WIDTH-1:0] not_out;

  assign or_out  = a | b;
  assign and_out = a & b;
  assign xor_out = a ^ b;
  assign not_out = ~a;

  always_comb begin
    out = or_out;
    case (logic_op_t'(op))
      OP_OR:   out = or_out;
      OP_AND:  out = and_out;
      OP_XOR:  out = xor_out;
      OP_NOT:  out = not_out;
      default: out = or_out;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// logic_unit_arbiter: round-robin sharing of one logic unit among N_REQ requesters,
// with a single registered, id-tagged result port.
module logic_unit_arbiter
  import logic_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int WIDTH = WORD_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*2-1:0]     req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data
);

  arb_state_t       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  next_ptr;
  logic             found;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] lu_out;
  int               idx;

  assign can_accept = (state == IDLE) || ((state == HOLD) && rsp_ready);

  // Scan from rr_ptr upward with wrap; first asserted valid wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = ID_W'(idx);
      if (!found && (|(req_valid & (N_REQ'(1) << cand)))) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    win_a     = '0;
    win_b     = '0;
    win_op    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        req_ready[i] = found && can_accept && !reset;
        win_a        = req_a[i*WIDTH +: WIDTH];
        win_b        = req_b[i*WIDTH +: WIDTH];
        win_op       = req_op[i*2 +: 2];
      end
    end
  end

  assign accept   = |(req_valid & req_ready);
  assign next_ptr = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;

  logic_unit_16 #(
    .WIDTH(WIDTH)
  ) u_logic_unit (
    .a  (win_a),
    .b  (win_b),
    .op (win_op),
    .out(lu_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= HOLD;
            rsp_valid <= 1'b1;
            rsp_id    <= winner;
            rsp_data  <= lu_out;
          end
        end
        HOLD: begin
          // Drain and refill on the same edge keeps one op per cycle.
          if (accept) begin
            rsp_valid <= 1'b1;
            rsp_id    <= winner;
            rsp_data  <= lu_out;
          end else if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
      if (accept) rr_ptr <= next_ptr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// tb_logic_unit_arbiter: scoreboard bench for the round-robin shared logic unit.
module tb_logic_unit_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int W  = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*2-1:0] req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_data;

  logic_unit_arbiter #(.N_REQ(N), .ID_W(IW), .WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_op   (req_op),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
  } rsp_t;

  rsp_t         q[$];
  int           m_ptr;
  bit           m_hold;
  logic [N-1:0] last_g;
  logic [N-1:0] exp_g;
  int           pass_cnt  = 0;
  int           total_cnt = 0;

  function automatic logic [W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return a | b;
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    int i;
    g = '0;
    if (reset || (m_hold && !rsp_ready)) return g;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (req_valid[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op);
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_op[i*2 +: 2] = op;
  endtask

  // Update the model with this cycle's handshakes, then move past the next edge.
  task automatic advance();
    logic [N-1:0] g;
    g = model_grant();
    if (reset) begin
      q.delete();
      m_ptr  = 0;
      m_hold = 1'b0;
    end else begin
      if (m_hold && rsp_ready) begin
        if (q.size() > 0) q.delete(0);
        m_hold = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          q.push_back({IW'(i), golden(req_a[i*W +: W], req_b[i*W +: W], req_op[i*2 +: 2])});
          m_ptr  = (i + 1) % N;
          m_hold = 1'b1;
        end
      end
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1; rsp_ready = 1'b1;
    advance();
    #2;
    total_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b exp 0000", req_ready);
    else pass_cnt++;
    advance();
    reset = 1'b0; req_valid = '0;
    #2;
    total_cnt++;
    if ({rsp_valid, rsp_id, rsp_data} !== 19'd0)
      $display("FAIL reset_outputs: got v=%b id=%0d d=%h exp all zero", rsp_valid, rsp_id, rsp_data);
    else pass_cnt++;
    advance();
  endtask

  task automatic test_single();
    set_req(0, 16'h00F0, 16'h0F00, 2'b00);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #2;
    total_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL single_grant: got %b exp 0001", req_ready);
    else pass_cnt++;
    advance();
    req_valid = '0;
    #2;
    total_cnt++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 16'h0FF0})
      $display("FAIL single_rsp: got v=%b id=%0d d=%h exp v=1 id=0 d=0ff0", rsp_valid, rsp_id, rsp_data);
    else pass_cnt++;
    advance();
  endtask

  task automatic test_round_robin();
    reset = 1'b1;
    advance();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 16'($urandom), 2'(i));
      req_valid = (c < 5) ? 4'b1111 : 4'b0000;
      rsp_ready = 1'b1;
      #2;
      exp_g = model_grant();
      if (c < 5) begin
        total_cnt++;
        if (req_ready !== (4'b0001 << (c % N)))
          $display("FAIL rr_order c=%0d: got %b exp %b", c, req_ready, 4'b0001 << (c % N));
        else pass_cnt++;
      end
      total_cnt++;
      if (rsp_valid !== m_hold) $display("FAIL rr_valid c=%0d: got %b exp %b", c, rsp_valid, m_hold);
      else pass_cnt++;
      if (m_hold) begin
        total_cnt++;
        if ({rsp_id, rsp_data} !== q[0])
          $display("FAIL rr_data c=%0d: got id=%0d d=%h exp id=%0d d=%h", c, rsp_id, rsp_data, q[0].id, q[0].data);
        else pass_cnt++;
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0110; rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 16'($urandom), 2'($urandom));
    #2;
    exp_g = model_grant();
    total_cnt++;
    if (req_ready !== exp_g) $display("FAIL bp_first: got %b exp %b", req_ready, exp_g);
    else pass_cnt++;
    advance();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 16'($urandom), 2'($urandom));
      #2;
      total_cnt++;
      if ({req_ready, rsp_valid, rsp_id, rsp_data} !== {4'b0000, 1'b1, q[0].id, q[0].data})
        $display("FAIL bp_hold c=%0d: got rdy=%b v=%b id=%0d d=%h exp rdy=0000 v=1 id=%0d d=%h",
                 c, req_ready, rsp_valid, rsp_id, rsp_data, q[0].id, q[0].data);
      else pass_cnt++;
      advance();
    end
    rsp_ready = 1'b1;
    #2;
    exp_g = model_grant();
    total_cnt++;
    if (req_ready !== exp_g || exp_g == 4'b0000)
      $display("FAIL bp_release: got %b exp %b", req_ready, exp_g);
    else pass_cnt++;
    advance();
    req_valid = '0;
    #2;
    total_cnt++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, q[0].id, q[0].data})
      $display("FAIL bp_rsp: got v=%b id=%0d d=%h exp v=1 id=%0d d=%h", rsp_valid, rsp_id, rsp_data, q[0].id, q[0].data);
    else pass_cnt++;
    advance();
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    advance();
    reset = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(i, 16'($urandom), 16'($urandom), 2'(i));
      req_valid = 4'b0001 << i;
      advance();
    end
    set_req(0, 16'h1234, 16'h00FF, 2'b01);
    set_req(3, 16'hAAAA, 16'($urandom), 2'b11);
    req_valid = 4'b1001;
    #2;
    total_cnt++;
    if (req_ready !== 4'b1000) $display("FAIL wrap_grant3: got %b exp 1000", req_ready);
    else pass_cnt++;
    advance();
    #2;
    total_cnt++;
    if ({req_ready, rsp_id, rsp_data} !== {4'b0001, 2'd3, 16'h5555})
      $display("FAIL wrap_grant0: got rdy=%b id=%0d d=%h exp rdy=0001 id=3 d=5555", req_ready, rsp_id, rsp_data);
    else pass_cnt++;
    advance();
    req_valid = '0;
    #2;
    total_cnt++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 16'h0034})
      $display("FAIL wrap_rsp0: got v=%b id=%0d d=%h exp v=1 id=0 d=0034", rsp_valid, rsp_id, rsp_data);
    else pass_cnt++;
    advance();
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0010; rsp_ready = 1'b0;
    advance();
    reset = 1'b1; req_valid = 4'b1111;
    #2;
    total_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL rmid_ready: got %b exp 0000", req_ready);
    else pass_cnt++;
    advance();
    reset = 1'b0;
    #2;
    total_cnt++;
    if ({rsp_valid, req_ready} !== {1'b0, 4'b0001})
      $display("FAIL rmid_after: got v=%b rdy=%b exp v=0 rdy=0001", rsp_valid, req_ready);
    else pass_cnt++;
    advance();
    req_valid = '0; rsp_ready = 1'b1;
    #2;
    total_cnt++;
    if ({rsp_valid, rsp_id} !== {1'b1, 2'd0})
      $display("FAIL rmid_rsp: got v=%b id=%0d exp v=1 id=0", rsp_valid, rsp_id);
    else pass_cnt++;
    advance();
  endtask

  task automatic test_random();
    int wait_cnt[N];
    bit any_acc;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      bit drain;
      drain = (c >= 9995);
      rsp_ready = drain ? 1'b1 : ($urandom % 4 != 0);
      for (int i = 0; i < N; i++) begin
        if (drain) req_valid[i] = 1'b0;
        else if (req_valid[i] && !last_g[i]) req_valid[i] = ($urandom % 50 != 0);
        else req_valid[i] = $urandom % 2;
        set_req(i, 16'($urandom), 16'($urandom), 2'($urandom));
      end
      #2;
      exp_g = model_grant();
      total_cnt++;
      if (req_ready !== exp_g) $display("FAIL rnd_grant c=%0d: got %b exp %b", c, req_ready, exp_g);
      else pass_cnt++;
      total_cnt++;
      if (rsp_valid !== m_hold) $display("FAIL rnd_valid c=%0d: got %b exp %b", c, rsp_valid, m_hold);
      else pass_cnt++;
      if (m_hold && rsp_ready) begin
        total_cnt++;
        if ({rsp_id, rsp_data} !== q[0])
          $display("FAIL rnd_data c=%0d: got id=%0d d=%h exp id=%0d d=%h", c, rsp_id, rsp_data, q[0].id, q[0].data);
        else pass_cnt++;
      end
      any_acc = |(req_valid & req_ready);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          total_cnt++;
          if (wait_cnt[i] >= N) $display("FAIL rnd_starve req=%0d: waited %0d exp < %0d", i, wait_cnt[i], N);
          else pass_cnt++;
          wait_cnt[i] = 0;
        end else if (!req_valid[i]) wait_cnt[i] = 0;
        else if (any_acc) wait_cnt[i]++;
      end
      advance();
    end
    #2;
    total_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL rnd_drained: got v=%b exp 0", rsp_valid);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    m_ptr = 0; m_hold = 1'b0; last_g = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 16-bit bitwise logic unit (OR / AND / XOR / NOT) between N_REQ independent requesters.
- Round-robin arbitration; each requester uses a valid/ready request handshake.
- One registered result port with a valid/ready handshake, tagged with the requester ID.
- Sits between the gate-level 16-bit chips and the control logic that needs them. Lets several clients time-multiplex a single logic datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of the requester ID.
- WIDTH, 16, operand and result width.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; one-hot or zero.
- req_a  input  N_REQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  input  N_REQ*WIDTH  operand B; same slicing as req_a.
- req_op  input  N_REQ*2  opcode per requester: 00 OR, 01 AND, 10 XOR, 11 NOT A.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  ID_W  index of the requester that owns rsp_data.
- rsp_data  output  WIDTH  registered result.

Behaviour:
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - Round-robin pointer rr_ptr=0; FSM state=IDLE.
  - req_ready=0 during the reset cycle.
- FSM states:
  - IDLE: no result held.
  - HOLD: a result is held and rsp_valid=1.
- can_accept = (state==IDLE) || (state==HOLD && rsp_ready).
- Arbitration (combinational):
  - Search from rr_ptr upward, wrapping modulo N_REQ; the first set req_valid bit wins.
  - req_ready[winner] = can_accept. All other req_ready bits are 0.
- Accept: req_valid[w] && req_ready[w] on an edge. Then:
  - rsp_data <= op(a_w, b_w); rsp_id <= w; state <= HOLD.
  - rr_ptr <= (w+1) mod N_REQ.
- Latency: result appears on rsp_* exactly 1 cycle after acceptance.
- Throughput: 1 op/cycle while rsp_ready=1. Drain and accept in the same edge are allowed.
- HOLD && rsp_ready && no valid request: state <= IDLE, rsp_valid <= 0. rsp_data and rsp_id hold their last values.
- HOLD && !rsp_ready:
  - rsp_data and rsp_id stay stable; rsp_valid stays 1.
  - All req_ready bits are 0.
  - rr_ptr is unchanged.
- rr_ptr changes only on acceptance; idle cycles do not rotate it.
- Requester rules:
  - A requester may deassert req_valid before it is accepted; no penalty, no state change.
  - Operands are sampled only on the accept edge.
- Wrap-around: winner N_REQ-1 sets rr_ptr to 0.
- Reset mid-operation: any held result is discarded at once. rsp_valid=0 on the cycle after reset is sampled, regardless of rsp_ready.
- Width: bitwise only, no carries. NOT A ignores b.
- Invalid N_REQ is out of scope; no runtime check.

Decomposition:
- Shared package logic_pkg:
  - typedef logic_op_t (2-bit enum OP_OR, OP_AND, OP_XOR, OP_NOT).
  - localparam WORD_W=16.
  - typedef arb_state_t (IDLE, HOLD).
- Sub-module logic_unit_16: purely combinational (a, b, op -> out).
  - Built from the existing 16-bit OR/AND/XOR/NOT chips.
  - Instantiated once, fed by the muxed winner operands.
- Round-robin search stays inline in the arbiter; it is too small to split out.

Test Plan:
- Reset, then req_valid=0001, req0 a=00F0 b=0F00 op=OR, rsp_ready=1.
  -> req_ready=0001 on that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=0FF0; rr_ptr=1.
- req_valid=1111 held continuously, rsp_ready=1, distinct ops.
  -> grants 0,1,2,3,0 in consecutive cycles; 1 result per cycle with matching ids; data equals a golden bitwise model.
- Result held with rsp_ready=0 for 3 cycles while req_valid=0110.
  -> rsp_data and rsp_id stable, req_ready=0000; on rsp_ready=1 the winner is the next index at or after rr_ptr, accepted the same cycle.
- Wrap: rr_ptr=3, req_valid=1001.
  -> req3 wins, then rr_ptr=0 and req0 wins next; req3 op=NOT a=AAAA -> rsp_data=5555 regardless of b.
- reset asserted while in HOLD with rsp_ready=0.
  -> next cycle rsp_valid=0, req_ready=0, rr_ptr=0; first post-reset grant with req_valid=1111 goes to req0.
- Random stress, 10k cycles, random valid/ready/operands.
  -> every accepted request produces exactly one response, in order, with the correct id and data.
  -> No starvation: a persistently valid requester is granted within N_REQ acceptances.
